// File: rtl/rf_wb_ctrl_pkg.sv
// Shared widths, load-queue entry layout and writeback-source encoding
// for the register-file writeback controller.
package rf_wb_ctrl_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;
   localparam int LDQ_DEPTH = 2;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic                 data_valid;
      logic [XLEN-1:0]      data;
   } ldq_entry_t;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_ALU  = 2'd1,
      SEL_LDQ  = 2'd2,
      SEL_BYP  = 2'd3
   } wb_sel_e;

endpackage

// File: rtl/rf_ldq.sv
// Two-entry in-order load queue: push on issue, fill the oldest entry still
// waiting for data, pop the head once its register-file write has been issued.
module rf_ldq
   import rf_wb_ctrl_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 i_push,
   input  logic [REG_IDX_W-1:0] i_push_rd,
   input  logic                 i_fill,
   input  logic [XLEN-1:0]      i_fill_data,
   input  logic                 i_pop,
   output logic [1:0]           o_count,
   output ldq_entry_t           o_head,
   output logic                 o_fill_ok,
   output logic                 o_fill_head,
   output logic                 o_head_rd_shared
);

   ldq_entry_t [LDQ_DEPTH-1:0] r_ent;
   logic [1:0]                 r_count;

   ldq_entry_t [LDQ_DEPTH-1:0] w_ent_nxt;
   logic [1:0]                 w_count_nxt;
   logic                       w_fill_tail;

   // Data arrives in order, so filled entries always form a prefix of the queue.
   assign o_fill_head      = (r_count != 2'd0) && !r_ent[0].data_valid;
   assign w_fill_tail      = (r_count == 2'(LDQ_DEPTH)) && r_ent[0].data_valid
                             && !r_ent[1].data_valid;
   assign o_fill_ok        = o_fill_head || w_fill_tail;
   assign o_count          = r_count;
   assign o_head           = r_ent[0];
   assign o_head_rd_shared = (r_count == 2'(LDQ_DEPTH)) && (r_ent[1].rd == r_ent[0].rd);

   always_comb begin
      w_ent_nxt   = r_ent;
      w_count_nxt = r_count;
      if (i_fill && o_fill_head) begin
         w_ent_nxt[0].data_valid = 1'b1;
         w_ent_nxt[0].data       = i_fill_data;
      end else if (i_fill && w_fill_tail) begin
         w_ent_nxt[1].data_valid = 1'b1;
         w_ent_nxt[1].data       = i_fill_data;
      end
      if (i_pop && (r_count != 2'd0)) begin
         w_ent_nxt[0] = w_ent_nxt[1];
         w_ent_nxt[1] = '0;
         w_count_nxt  = w_count_nxt - 2'd1;
      end
      if (i_push && (w_count_nxt != 2'(LDQ_DEPTH))) begin
         w_ent_nxt[w_count_nxt[0]] = '{rd: i_push_rd, data_valid: 1'b0, data: '0};
         w_count_nxt               = w_count_nxt + 2'd1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_ent   <= '0;
         r_count <= 2'd0;
      end else begin
         r_ent   <= w_ent_nxt;
         r_count <= w_count_nxt;
      end
   end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-port arbiter between ALU results and in-order load
// returns, with a busy scoreboard driving the decode-stage stall.
module rf_wb_ctrl
   import rf_wb_ctrl_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 alu_we_i,
   input  logic [REG_IDX_W-1:0] alu_rd_i,
   input  logic [XLEN-1:0]      alu_wd_i,
   input  logic                 ld_issue_i,
   input  logic [REG_IDX_W-1:0] ld_rd_i,
   output logic                 ld_ready_o,
   input  logic                 ld_valid_i,
   input  logic [XLEN-1:0]      ld_data_i,
   input  logic [REG_IDX_W-1:0] rs1_i,
   input  logic [REG_IDX_W-1:0] rs2_i,
   input  logic [REG_IDX_W-1:0] rd_chk_i,
   output logic                 stall_o,
   output logic                 WE3_o,
   output logic [REG_IDX_W-1:0] addr_3_o,
   output logic [XLEN-1:0]      WD3_o,
   output logic                 err_o
);

   logic [31:0]          r_busy;
   logic                 r_err;

   logic [1:0]           w_count;
   ldq_entry_t           w_head;
   logic                 w_fill_ok;
   logic                 w_fill_head;
   logic                 w_head_rd_shared;
   logic                 w_push;
   logic                 w_fill;
   logic                 w_pop;
   wb_sel_e              w_sel;
   logic [REG_IDX_W-1:0] w_sel_rd;
   logic [XLEN-1:0]      w_sel_wd;
   logic [31:0]          w_busy_nxt;
   logic                 w_err_evt;

   rf_ldq u_ldq (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .i_push           (w_push),
      .i_push_rd        (ld_rd_i),
      .i_fill           (w_fill),
      .i_fill_data      (ld_data_i),
      .i_pop            (w_pop),
      .o_count          (w_count),
      .o_head           (w_head),
      .o_fill_ok        (w_fill_ok),
      .o_fill_head      (w_fill_head),
      .o_head_rd_shared (w_head_rd_shared)
   );

   assign ld_ready_o = (w_count != 2'(LDQ_DEPTH));
   assign w_push     = ld_issue_i && ld_ready_o;
   assign w_fill     = ld_valid_i && w_fill_ok;
   assign stall_o    = r_busy[rs1_i] | r_busy[rs2_i] | r_busy[rd_chk_i];
   assign err_o      = r_err;

   // ALU first, then a head entry that already holds data, then a same-cycle bypass.
   always_comb begin
      w_sel    = SEL_NONE;
      w_sel_rd = '0;
      w_sel_wd = '0;
      w_pop    = 1'b0;
      if (alu_we_i) begin
         w_sel    = SEL_ALU;
         w_sel_rd = alu_rd_i;
         w_sel_wd = alu_wd_i;
      end else if ((w_count != 2'd0) && w_head.data_valid) begin
         w_sel    = SEL_LDQ;
         w_sel_rd = w_head.rd;
         w_sel_wd = w_head.data;
         w_pop    = 1'b1;
      end else if (w_fill && w_fill_head) begin
         w_sel    = SEL_BYP;
         w_sel_rd = w_head.rd;
         w_sel_wd = ld_data_i;
         w_pop    = 1'b1;
      end
   end

   // Set after clear, so a new issue to the retiring rd keeps it busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_pop && !w_head_rd_shared) begin
         w_busy_nxt[w_head.rd] = 1'b0;
      end
      if (w_push) begin
         w_busy_nxt[ld_rd_i] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   assign w_err_evt = (ld_issue_i && !ld_ready_o)
                    | (ld_valid_i && !w_fill_ok)
                    | (alu_we_i && r_busy[alu_rd_i]);

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_busy   <= '0;
         r_err    <= 1'b0;
         WE3_o    <= 1'b0;
         addr_3_o <= '0;
         WD3_o    <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_err  <= r_err | w_err_evt;
         WE3_o  <= (w_sel != SEL_NONE) && (w_sel_rd != '0);
         if (w_sel != SEL_NONE) begin
            addr_3_o <= w_sel_rd;
            WD3_o    <= w_sel_wd;
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: expected port writes are queued at stimulus
// time and popped by a negedge monitor; control outputs are checked inline.
module tb_rf_wb_ctrl;

   logic        clk_i;
   logic        reset_i;
   logic        alu_we_i;
   logic [4:0]  alu_rd_i;
   logic [31:0] alu_wd_i;
   logic        ld_issue_i;
   logic [4:0]  ld_rd_i;
   logic        ld_ready_o;
   logic        ld_valid_i;
   logic [31:0] ld_data_i;
   logic [4:0]  rs1_i;
   logic [4:0]  rs2_i;
   logic [4:0]  rd_chk_i;
   logic        stall_o;
   logic        WE3_o;
   logic [4:0]  addr_3_o;
   logic [31:0] WD3_o;
   logic        err_o;

   logic [36:0] exp_q[$];
   int          n_checks;
   int          n_fail;

   rf_wb_ctrl dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .alu_we_i   (alu_we_i),
      .alu_rd_i   (alu_rd_i),
      .alu_wd_i   (alu_wd_i),
      .ld_issue_i (ld_issue_i),
      .ld_rd_i    (ld_rd_i),
      .ld_ready_o (ld_ready_o),
      .ld_valid_i (ld_valid_i),
      .ld_data_i  (ld_data_i),
      .rs1_i      (rs1_i),
      .rs2_i      (rs2_i),
      .rd_chk_i   (rd_chk_i),
      .stall_o    (stall_o),
      .WE3_o      (WE3_o),
      .addr_3_o   (addr_3_o),
      .WD3_o      (WD3_o),
      .err_o      (err_o)
   );

   // clock / reset
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge clk_i);
      #1;
      alu_we_i   = 1'b0;
      ld_issue_i = 1'b0;
      ld_valid_i = 1'b0;
   endtask

   task automatic alu_wr(input logic [4:0] rd, input logic [31:0] wd);
      alu_we_i = 1'b1;
      alu_rd_i = rd;
      alu_wd_i = wd;
      if (rd != 5'd0) exp_q.push_back({rd, wd});
   endtask

   task automatic ld_issue(input logic [4:0] rd);
      ld_issue_i = 1'b1;
      ld_rd_i    = rd;
   endtask

   task automatic ld_resp(input logic [4:0] rd, input logic [31:0] d, input bit expect_wr);
      ld_valid_i = 1'b1;
      ld_data_i  = d;
      if (expect_wr) exp_q.push_back({rd, d});
   endtask

   // scoreboard monitor
   initial begin
      logic [36:0] e;
      forever begin
         @(negedge clk_i);
         if (reset_i === 1'b1 && WE3_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write actual=%0h/%0h expected=none", addr_3_o, WD3_o);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 64'(addr_3_o), 64'(e[36:32]));
               chk("wr_data", 64'(WD3_o), 64'(e[31:0]));
            end
         end
      end
   end

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset_i    = 1'b0;
      alu_we_i   = 1'b0;
      alu_rd_i   = '0;
      alu_wd_i   = '0;
      ld_issue_i = 1'b0;
      ld_rd_i    = '0;
      ld_valid_i = 1'b0;
      ld_data_i  = '0;
      rs1_i      = '0;
      rs2_i      = '0;
      rd_chk_i   = '0;
      step();
      step();
      chk("rst_we", 64'(WE3_o), 64'd0);
      chk("rst_addr", 64'(addr_3_o), 64'd0);
      chk("rst_wd", 64'(WD3_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_ready", 64'(ld_ready_o), 64'd1);
      chk("rst_stall", 64'(stall_o), 64'd0);
      reset_i = 1'b1;
      step();

      // ALU only, then an x0 write
      alu_wr(5'd5, 32'hDEADBEEF);
      step();
      chk("alu_we", 64'(WE3_o), 64'd1);
      alu_wr(5'd0, 32'h00001234);
      step();
      chk("alu_x0_we", 64'(WE3_o), 64'd0);
      chk("alu_err", 64'(err_o), 64'd0);

      // load bypass with stall window
      rs1_i = 5'd7;
      ld_issue(5'd7);
      chk("byp_stall_pre", 64'(stall_o), 64'd0);
      step();
      chk("byp_stall_issued", 64'(stall_o), 64'd1);
      chk("byp_ready", 64'(ld_ready_o), 64'd1);
      step();
      chk("byp_stall_wait", 64'(stall_o), 64'd1);
      ld_resp(5'd7, 32'h12345678, 1'b1);
      chk("byp_stall_resp", 64'(stall_o), 64'd1);
      step();
      chk("byp_we", 64'(WE3_o), 64'd1);
      chk("byp_stall_post", 64'(stall_o), 64'd0);
      step();

      // response colliding with an ALU write
      rs1_i = 5'd8;
      ld_issue(5'd8);
      step();
      alu_wr(5'd3, 32'h00000033);
      ld_resp(5'd8, 32'hA5A5A5A5, 1'b1);
      step();
      chk("col_alu_addr", 64'(addr_3_o), 64'd3);
      chk("col_stall_held", 64'(stall_o), 64'd1);
      step();
      chk("col_ld_addr", 64'(addr_3_o), 64'd8);
      chk("col_stall_clr", 64'(stall_o), 64'd0);
      chk("col_err", 64'(err_o), 64'd0);

      // full queue, same rd twice
      rs1_i = 5'd9;
      ld_issue(5'd9);
      step();
      chk("full_ready1", 64'(ld_ready_o), 64'd1);
      ld_issue(5'd9);
      step();
      chk("full_ready0", 64'(ld_ready_o), 64'd0);
      chk("full_stall", 64'(stall_o), 64'd1);
      chk("full_err0", 64'(err_o), 64'd0);
      ld_issue(5'd9);
      step();
      chk("full_err1", 64'(err_o), 64'd1);
      chk("full_ready_still0", 64'(ld_ready_o), 64'd0);
      ld_resp(5'd9, 32'h11111111, 1'b1);
      step();
      chk("full_stall_after1", 64'(stall_o), 64'd1);
      chk("full_ready_after1", 64'(ld_ready_o), 64'd1);
      ld_resp(5'd9, 32'h22222222, 1'b1);
      step();
      chk("full_stall_after2", 64'(stall_o), 64'd0);
      chk("full_err_sticky", 64'(err_o), 64'd1);
      step();

      // asynchronous reset mid-cycle
      rs1_i = 5'd10;
      ld_issue(5'd10);
      alu_wr(5'd4, 32'h00000044);
      step();
      chk("pre_rst_we", 64'(WE3_o), 64'd1);
      chk("pre_rst_stall", 64'(stall_o), 64'd1);
      @(negedge clk_i);
      #1;
      reset_i = 1'b0;
      #1;
      chk("arst_we", 64'(WE3_o), 64'd0);
      chk("arst_addr", 64'(addr_3_o), 64'd0);
      chk("arst_wd", 64'(WD3_o), 64'd0);
      chk("arst_err", 64'(err_o), 64'd0);
      chk("arst_ready", 64'(ld_ready_o), 64'd1);
      chk("arst_stall", 64'(stall_o), 64'd0);
      step();
      reset_i = 1'b1;
      step();

      // spurious response with an empty queue
      ld_resp(5'd0, 32'h00000099, 1'b0);
      step();
      chk("spur_err", 64'(err_o), 64'd1);
      chk("spur_we", 64'(WE3_o), 64'd0);

      // loads to x0 consume entries but never write or stall
      rs1_i = 5'd0;
      ld_issue(5'd0);
      step();
      ld_issue(5'd0);
      step();
      chk("x0_ready0", 64'(ld_ready_o), 64'd0);
      chk("x0_stall", 64'(stall_o), 64'd0);
      ld_resp(5'd0, 32'h00000055, 1'b0);
      step();
      ld_resp(5'd0, 32'h00000066, 1'b0);
      step();
      chk("x0_ready1", 64'(ld_ready_o), 64'd1);
      chk("x0_we", 64'(WE3_o), 64'd0);

      step();
      step();
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
